// File: rtl/muldiv_unit_if.sv
// Core-side bus of the multiply/divide unit: launch, HI/LO moves and results.
interface muldiv_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wd;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b, mthi, mtlo, wd,
                  input  busy, done, hi, lo);
  modport slave  (input  start, op, a, b, mthi, mtlo, wd,
                  output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style multiply/divide unit with fixed 34-cycle latency
// and HI/LO result registers.
module muldiv_unit (
  input  logic           clk,
  input  logic           reset,
  muldiv_unit_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;
  typedef enum logic [1:0] {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU} op_t;

  state_t      state, state_n;
  op_t         op_r;
  logic [31:0] a_r, b_r;
  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [31:0] hi_r, lo_r;

  logic        is_div, signed_op, neg_a, neg_b;
  logic [31:0] mag_a, mag_b;
  logic [63:0] acc_cur, mult_next, div_next, prod_neg;
  logic [32:0] msum, shifted;
  logic [31:0] dsub, q_res, r_res;
  logic        borrow;
  logic [31:0] res_hi, res_lo;

  assign is_div    = (op_r == OP_DIV) || (op_r == OP_DIVU);
  assign signed_op = (op_r == OP_MULT) || (op_r == OP_DIV);
  assign neg_a     = signed_op & a_r[31];
  assign neg_b     = signed_op & b_r[31];
  assign mag_a     = neg_a ? (32'd0 - a_r) : a_r;
  assign mag_b     = neg_b ? (32'd0 - b_r) : b_r;

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient};
  // the first iteration seeds it from the operand magnitudes.
  assign acc_cur   = (cnt == 5'd0) ? {32'd0, (is_div ? mag_a : mag_b)} : acc;

  assign msum      = {1'b0, acc_cur[63:32]} + (acc_cur[0] ? {1'b0, mag_a} : 33'd0);
  assign mult_next = {msum, acc_cur[31:1]};

  assign shifted   = {acc_cur[63:32], acc_cur[31]};
  assign borrow    = shifted < {1'b0, mag_b};
  assign dsub      = shifted[31:0] - mag_b;
  assign div_next  = borrow ? {shifted[31:0], acc_cur[30:0], 1'b0}
                            : {dsub,          acc_cur[30:0], 1'b1};

  assign prod_neg  = 64'd0 - acc;
  assign q_res     = (neg_a ^ neg_b) ? (32'd0 - acc[31:0]) : acc[31:0];
  assign r_res     = neg_a ? (32'd0 - acc[63:32]) : acc[63:32];

  always_comb begin
    res_hi = acc[63:32];
    res_lo = acc[31:0];
    if (is_div) begin
      if (b_r == 32'd0) begin
        res_hi = a_r;
        res_lo = '1;
      end else begin
        res_hi = r_res;
        res_lo = q_res;
      end
    end else if (neg_a ^ neg_b) begin
      res_hi = prod_neg[63:32];
      res_lo = prod_neg[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.start) state_n = CALC;
      CALC:    if (cnt == 5'd31) state_n = SIGN;
      SIGN:    state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_r <= OP_MULT;
      a_r  <= '0;
      b_r  <= '0;
      cnt  <= '0;
      acc  <= '0;
      hi_r <= '0;
      lo_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_r <= op_t'(bus.op);
            a_r  <= bus.a;
            b_r  <= bus.b;
            cnt  <= '0;
          end else begin
            if (bus.mthi) hi_r <= bus.wd;
            if (bus.mtlo) lo_r <= bus.wd;
          end
        end
        CALC: begin
          acc <= is_div ? div_next : mult_next;
          cnt <= cnt + 5'd1;
        end
        SIGN: begin
          hi_r <= res_hi;
          lo_r <= res_lo;
        end
        DONE: begin
          if (bus.mthi) hi_r <= bus.wd;
          if (bus.mtlo) lo_r <= bus.wd;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state == CALC) || (state == SIGN);
  assign bus.done = (state == DONE);
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed operations, HI/LO moves and reset abort.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_unit_if bus ();
  muldiv_unit dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          start;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   act_s  = -1;
  int   n_pass = 0;
  int   n_tot  = 0;
  logic mon_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor: cycle r of an operation is the period ending at edge act_s + r.
  always @(negedge clk) begin
    exp_t e;
    int   rel;
    logic eb;
    if (mon_on) begin
      rel = cyc - act_s + 1;
      eb  = (act_s >= 0) && (rel >= 1) && (rel <= 33);
      check32("busy", {31'd0, bus.busy}, {31'd0, eb});
      if (bus.done === 1'b1) begin
        if (sb.size() == 0) begin
          n_tot++;
          $display("FAIL unexpected_done: done=1 at cycle %0d, required 0", cyc);
        end else begin
          e = sb.pop_front();
          check32({e.name, "_hi"}, bus.hi, e.hi);
          check32({e.name, "_lo"}, bus.lo, e.lo);
          check32({e.name, "_latency"}, 32'(cyc - e.start + 1), 32'd34);
          act_s = -1;
        end
      end else if (sb.size() > 0 && (cyc - sb[0].start + 1) > 34) begin
        e = sb.pop_front();
        n_tot++;
        $display("FAIL %s_missing_done: done=0 at cycle 34, required 1", e.name);
        act_s = -1;
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input string nm,
                       input logic with_mthi);
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    bus.mthi  = with_mthi; bus.wd = 32'hAAAAAAAA;
    @(posedge clk);
    #1;
    act_s   = cyc;
    e.hi    = eh;
    e.lo    = el;
    e.start = cyc;
    e.name  = nm;
    sb.push_back(e);
    bus.start = 1'b0; bus.mthi = 1'b0;
    bus.a = $urandom; bus.b = $urandom; bus.op = 2'($urandom);
  endtask

  task automatic wait_rel(input int k);
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while ((cyc - act_s + 1) < k && g < 100);
  endtask

  task automatic wait_done(input string nm);
    int g = 0;
    while (sb.size() > 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (sb.size() > 0) begin
      n_tot++;
      $display("FAIL %s_timeout: queue=%0d required 0", nm, sb.size());
      sb.delete();
      act_s = -1;
    end
    @(negedge clk);
  endtask

  task automatic move(input logic wh, input logic wl, input logic [31:0] d);
    @(negedge clk);
    bus.mthi = wh; bus.mtlo = wl; bus.wd = d;
    @(posedge clk);
    #1;
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wd = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check32("rst_busy", {31'd0, bus.busy}, 32'd0);
    check32("rst_done", {31'd0, bus.done}, 32'd0);
    check32("rst_hi", bus.hi, 32'd0);
    check32("rst_lo", bus.lo, 32'd0);
    mon_on = 1'b1;

    issue(2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, "mult_m3x5", 1'b0);
    wait_done("mult_m3x5");
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max", 1'b0);
    wait_done("multu_max");
    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, "mult_m1xm1", 1'b0);
    wait_done("mult_m1xm1");
    issue(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7d2", 1'b0);
    wait_done("div_m7d2");
    issue(2'b10, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_7dm2", 1'b0);
    wait_done("div_7dm2");
    issue(2'b11, 32'd7, 32'd0, 32'h00000007, 32'hFFFFFFFF, "divu_by0", 1'b0);
    wait_done("divu_by0");

    // Overflow divide with a second start that must be ignored
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_ovf", 1'b0);
    wait_rel(5);
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd5; bus.b = 32'd5;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done("div_ovf");

    move(1'b1, 1'b0, 32'h12345678);
    check32("mthi_hi", bus.hi, 32'h12345678);

    issue(2'b01, 32'd3, 32'd4, 32'h00000000, 32'h0000000C, "multu_3x4", 1'b0);
    wait_rel(10);
    bus.mtlo = 1'b1; bus.wd = 32'hDEADBEEF;
    @(posedge clk);
    #1 bus.mtlo = 1'b0;
    @(negedge clk);
    check32("busy_mtlo_lo", bus.lo, 32'h80000000);
    wait_done("multu_3x4");

    move(1'b1, 1'b1, 32'h55AA55AA);
    check32("both_hi", bus.hi, 32'h55AA55AA);
    check32("both_lo", bus.lo, 32'h55AA55AA);

    issue(2'b01, 32'd2, 32'd3, 32'h00000000, 32'h00000006, "start_wins", 1'b1);
    @(negedge clk);
    check32("start_wins_hi_hold", bus.hi, 32'h55AA55AA);
    wait_done("start_wins");

    // Reset mid-operation: abort, clear HI/LO, no done afterwards
    issue(2'b00, 32'd100, 32'd100, 32'h00000000, 32'd10000, "mult_abort", 1'b0);
    wait_rel(10);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    act_s = -1;
    @(negedge clk);
    check32("abort_busy", {31'd0, bus.busy}, 32'd0);
    check32("abort_done", {31'd0, bus.done}, 32'd0);
    check32("abort_hi", bus.hi, 32'd0);
    check32("abort_lo", bus.lo, 32'd0);
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have exactly one clock and SHALL use a synchronous, active-high reset.
REQ-002 The ports SHALL be as follows (name, direction, width, meaning):
- clk    in   1   rising-edge clock, shared with the register file
- reset  in   1   synchronous active-high reset
- start  in   1   launch the operation selected by op
- op     in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a      in   32  operand rs (register file read port 1)
- b      in   32  operand rt (register file read port 2)
- mthi   in   1   write wd to HI
- mtlo   in   1   write wd to LO
- wd     in   32  data for mthi/mtlo
- busy   out  1   operation in progress; the core stalls on mfhi/mflo/start while busy=1
- done   out  1   one-cycle pulse; hi/lo hold the new result
- hi     out  32  HI register: mult upper word or div remainder
- lo     out  32  LO register: mult lower word or div quotient

Function
REQ-003 The block SHALL implement an FSM with four states: IDLE, CALC, SIGN and DONE.
REQ-004 IDLE SHALL behave as follows:
- start=1 at a clock edge latches a, b and op, clears the iteration counter, and moves to CALC.
- start=0 stays in IDLE.
REQ-005 CALC SHALL last exactly 32 cycles, performing one radix-2 iteration per cycle on the operand magnitudes:
- multiply: shift-add, 64-bit product.
- divide: restoring shift-subtract, 32-bit quotient and 32-bit remainder.
- After 32 iterations the FSM moves to SIGN.
REQ-006 SIGN SHALL last one cycle and apply the sign correction:
- MULT: negate the 64-bit product when a[31] XOR b[31].
- DIV: negate the quotient when the signs differ; the remainder takes the sign of a.
- MULTU/DIVU: no correction.
- At the end of SIGN, hi and lo load the result and the FSM moves to DONE.
REQ-007 DONE SHALL last one cycle with done=1, then return to IDLE. start in DONE is ignored.
REQ-008 Latency SHALL be fixed:
- start sampled at edge 0.
- busy=1 in cycles 1-33.
- done=1 and new hi/lo visible in cycle 34.
- This holds for all ops and operand values.
REQ-009 busy SHALL be 1 exactly in CALC and SIGN; done SHALL be 1 exactly in DONE.
REQ-010 Operand registers SHALL be captured at start; changes on a, b or op during CALC SHALL NOT affect the result.
REQ-011 start, mthi and mtlo SHALL be ignored while busy=1.
REQ-012 In IDLE or DONE, mthi (mtlo) SHALL write wd to hi (lo) at the next edge. When both are asserted, both registers are written.
REQ-013 When start and mthi/mtlo are both asserted in IDLE, start SHALL win; no hi/lo write occurs and the result later overwrites hi/lo.
REQ-014 Divide by zero (b=0, DIV or DIVU) SHALL give hi=a and lo=32'hFFFFFFFF, with the same 34-cycle latency.
REQ-015 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL give lo=32'h80000000 and hi=0 (wrap, no trap).
REQ-016 hi and lo SHALL otherwise hold their value; they are never modified during CALC or SIGN.
REQ-017 The multiply result SHALL be the exact 64-bit two's-complement (MULT) or unsigned (MULTU) product, with hi = bits 63:32 and lo = bits 31:0.

Reset
REQ-018 reset=1 at a clock edge SHALL force the FSM to IDLE and set busy=0, done=0, hi=0, lo=0, the iteration counter to 0 and the operand registers to 0.
REQ-019 Reset SHALL take priority over start, mthi and mtlo, and SHALL abort any in-progress operation with no hi/lo update.

Verification
REQ-020 MULT a=32'hFFFFFFFD (-3), b=5 -> done in cycle 34; hi=32'hFFFFFFFF, lo=32'hFFFFFFF1; busy high for exactly cycles 1-33.
REQ-021 MULTU a=b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-022 DIV a=32'hFFFFFFF9 (-7), b=2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1); and DIVU a=7, b=0 -> hi=7, lo=32'hFFFFFFFF.
REQ-023 DIV a=32'h80000000, b=32'hFFFFFFFF -> lo=32'h80000000, hi=0; a second start pulsed in cycle 5 is ignored (only one done pulse, still at cycle 34).
REQ-024 mthi wd=32'h12345678 in IDLE -> hi=32'h12345678 next cycle. Then start MULTU 3*4 with mtlo=1, wd=32'hDEADBEEF pulsed in cycle 10 -> mtlo ignored; lo=12, hi=0 at done.
REQ-025 Start MULT 100*100, then assert reset in cycle 10 -> next cycle busy=0, done=0, hi=lo=0, FSM in IDLE; no done pulse follows.
